// File: rtl/hex_scroll_ctrl_if.sv
// Avalon-MM slave bus bundle for hex_scroll_ctrl.
// The CPU side (master) drives address/strobes/data and reads back readdata.
interface hex_scroll_ctrl_if;
   logic [4:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolling / blinking seven-segment message controller.
// A 16-entry message buffer (hex digits or raw patterns) is shown on
// NUM_DIGITS displays; a prescaler generates step pulses that advance the
// scroll position and toggle the blink phase without CPU involvement.
module hex_scroll_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   hex_scroll_ctrl_if.slave          avs,
   output logic [NUM_DIGITS*7-1:0]   hex_out
);

   localparam int                    HEX_W     = NUM_DIGITS * 7;
   localparam logic [23:0]           RATE_RST  = 24'hBEBC20;
   localparam logic [3:0]            LEN_RST   = 4'd15;
   localparam logic [7:0]            MSG_RST   = 8'h80;
   localparam logic [HEX_W-1:0]      INV_MASK  = {HEX_W{ACTIVE_LOW}};

   // Hex digit to segment glyph, segment a in bit 0.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   // ---------------------------------------------------------------
   // Register state
   // ---------------------------------------------------------------
   logic [1:0]       ctrl_reg,  ctrl_next;
   logic [23:0]      rate_reg;
   logic [3:0]       len_reg;
   logic [23:0]      presc_reg, presc_next;
   logic [3:0]       pos_reg,   pos_next;
   logic             blink_reg, blink_next;
   logic [HEX_W-1:0] hex_out_reg, hex_out_next;
   logic [7:0]       msg_mem_reg [16];

   // ---------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------
   logic        wr_en;
   logic        wr_ctrl, wr_rate, wr_len, wr_msg;
   logic        restart;
   logic        unused_wdata;

   assign wr_en   = avs.chipselect & ~avs.write_n;
   assign wr_ctrl = wr_en && (avs.address == 5'd0);
   assign wr_rate = wr_en && (avs.address == 5'd1);
   assign wr_len  = wr_en && (avs.address == 5'd3);
   assign wr_msg  = wr_en && avs.address[4];
   assign restart = wr_ctrl && avs.writedata[2];

   // Upper write-data bits have no destination in any register.
   assign unused_wdata = &{1'b0, avs.writedata[31:24]};

   // Enable bits as they will be after this edge; blink clearing follows them.
   assign ctrl_next = wr_ctrl ? avs.writedata[1:0] : ctrl_reg;

   // ---------------------------------------------------------------
   // Prescaler / step generation
   // ---------------------------------------------------------------
   logic        run;
   logic        step;
   logic [23:0] rate_last;

   // RATE of 0 is treated as 1, so the terminal count is never below 0.
   assign rate_last = (rate_reg == 24'd0) ? 24'd0 : rate_reg - 24'd1;
   assign run       = |ctrl_reg;
   assign step      = run && (presc_reg == rate_last);

   // Next prescaler count: held at 0 when idle, cleared by restart/RATE write/step.
   always_comb begin
      presc_next = presc_reg + 24'd1;
      if (!run || restart || wr_rate || step) begin
         presc_next = 24'd0;
      end
   end

   // Next scroll position: restart wins over a coincident step.
   always_comb begin
      pos_next = pos_reg;
      if (restart) begin
         pos_next = 4'd0;
      end else if (step && ctrl_reg[0]) begin
         pos_next = (pos_reg >= len_reg) ? 4'd0 : pos_reg + 4'd1;
      end
   end

   // Next blink phase: forced low when blinking is off, toggled on step otherwise.
   always_comb begin
      blink_next = blink_reg;
      if (restart || !ctrl_next[1]) begin
         blink_next = 1'b0;
      end else if (step && ctrl_reg[1]) begin
         blink_next = ~blink_reg;
      end
   end

   // Control, rate, length and sequencing state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_reg  <= 2'd0;
         rate_reg  <= RATE_RST;
         len_reg   <= LEN_RST;
         presc_reg <= 24'd0;
         pos_reg   <= 4'd0;
         blink_reg <= 1'b0;
      end else begin
         ctrl_reg  <= ctrl_next;
         if (wr_rate) begin
            rate_reg <= avs.writedata[23:0];
         end
         if (wr_len) begin
            len_reg <= avs.writedata[3:0];
         end
         presc_reg <= presc_next;
         pos_reg   <= pos_next;
         blink_reg <= blink_next;
      end
   end

   // ---------------------------------------------------------------
   // Message buffer, one register per entry so every entry resets to blank
   // and all displays can read it at once.
   // ---------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_msg
         // Entry gi storage, written when the low address nibble selects it.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               msg_mem_reg[gi] <= MSG_RST;
            end else if (wr_msg && (avs.address[3:0] == 4'(gi))) begin
               msg_mem_reg[gi] <= avs.writedata[7:0];
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------
   // Display mapping: digit d shows MSG[(pos + NUM_DIGITS-1-d) mod 16]
   // ---------------------------------------------------------------
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         localparam logic [3:0] OFS = 4'((NUM_DIGITS - 1 - gi) % 16);
         logic [3:0] idx;
         logic [7:0] entry;
         logic [6:0] seg;

         assign idx   = pos_reg + OFS;
         assign entry = msg_mem_reg[idx];
         assign seg   = entry[7] ? entry[6:0] : hex_glyph(entry[3:0]);
         assign hex_out_next[gi*7 +: 7] = (blink_reg ? 7'd0 : seg) ^ INV_MASK[gi*7 +: 7];
      end
   endgenerate

   // Registered segment outputs; blank pattern while in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_out_reg <= INV_MASK;
      end else begin
         hex_out_reg <= hex_out_next;
      end
   end

   assign hex_out = hex_out_reg;

   // Zero-wait-state read mux, zero-extended; unmapped addresses read 0.
   always_comb begin
      avs.readdata = 32'd0;
      case (avs.address)
         5'd0:    avs.readdata = {30'd0, ctrl_reg};
         5'd1:    avs.readdata = {8'd0, rate_reg};
         5'd2:    avs.readdata = {27'd0, blink_reg, pos_reg};
         5'd3:    avs.readdata = {28'd0, len_reg};
         default: begin
            if (avs.address[4]) begin
               avs.readdata = {24'd0, msg_mem_reg[avs.address[3:0]]};
            end
         end
      endcase
   end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Avalon-MM slave that drives a bank of seven-segment displays from a 16-entry message buffer. The Nios II core writes hex digits or raw segment patterns into the buffer. The block then scrolls the message across the displays and optionally blinks it, all in hardware and without further CPU writes. It replaces per-display output PIOs on the system interconnect: one slave, one combined segment bus to the board pins.

## Interface
- `NUM_DIGITS`, default 6: number of physical displays driven.
- `ACTIVE_LOW`, default 1: 1 means segment outputs are inverted (0 = lit).
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `address` input, 5 bits: register select, word-addressed.
- `chipselect` input, 1 bit: slave select.
- `write_n` input, 1 bit: active-low write strobe.
- `writedata` input, 32 bits: write data.
- `readdata` output, 32 bits: read data, combinational from `address`, zero-extended.
- `hex_out` output, NUM_DIGITS*7 bits: segments; digit d occupies bits [7d+6:7d], segment a in the LSB.

## Operation
- Write strobe is `chipselect && !write_n`; the address decodes as follows.
- Address 0, CTRL (R/W):
  - bit0 `scroll_en`, bit1 `blink_en`.
  - bit2 `restart` is write-1 action and reads as 0.
  - Reset value is 0.
- Address 1, RATE (R/W): [23:0] step period in clocks.
  - Reset value is 24'hBEBC20 (4 steps/s at 50 MHz).
  - A value of 0 behaves as 1.
- Address 2, STATUS (RO): [3:0] `pos`, [4] `blink_phase`. Writes are ignored.
- Address 3, LEN (R/W): [3:0] message length minus 1. Reset value is 15.
- Addresses 16–31, MSG[0..15] (R/W), 8 bits each:
  - bit7=1: bits[6:0] are a raw segment pattern (1 = lit).
  - bit7=0: bits[3:0] are a hex digit, decoded 0–F to the standard 7-segment glyphs.
  - Reset value is 8'h80 (blank) for every entry.
- Unmapped addresses read 0; writes to them are ignored.
- Prescaler (24 bits):
  - Runs only while `scroll_en | blink_en`; otherwise it is held at 0.
  - When it equals max(RATE,1)-1 it returns to 0 and issues a one-cycle `step`.
- On `step`:
  - If `scroll_en`: `pos` <= (`pos` >= LEN) ? 0 : `pos`+1.
  - If `blink_en`: `blink_phase` toggles.
- `blink_en`=0 forces `blink_phase` to 0 on the next clock.
- Display mapping: digit d shows MSG[(`pos` + NUM_DIGITS-1-d) mod 16]. The leftmost digit shows MSG[`pos`], and the text moves left as `pos` increments.
- Buffer indexing is always mod 16; LEN only sets where `pos` wraps.
- Blanking: when `blink_phase`=1, all digits are blank.
- `hex_out` is the logical pattern, XOR-inverted when ACTIVE_LOW=1.

## Timing
- Reset (asynchronous):
  - `pos`=0, `blink_phase`=0, prescaler=0, all registers at their reset values.
  - `hex_out` is all ones when ACTIVE_LOW=1, otherwise all zeros.
- Reads have zero wait states; `readdata` is valid in the same cycle as `address`.
- A register write takes effect on the clock edge of the write. `hex_out` is registered and reflects the new state one clock later.
- RATE write: the prescaler clears to 0 on the same edge, so the next `step` comes RATE clocks later.
- `restart` write: `pos`, `blink_phase` and the prescaler clear to 0 on the same edge. This has priority over a coincident `step`.
- CTRL enable bits written in the same word as `restart` take effect together with it.
- LEN written smaller than the current `pos`: no immediate change; the next scroll `step` wraps `pos` to 0.
- A MSG write coincident with a `step`: both take effect, and the display uses the new entry and new `pos` on the following clock.
- With RATE=1 and `scroll_en`=1, `pos` advances every clock.

## Test plan
- Display mapping:
  - Stimulus: reset; write MSG[0..5]=0..5 (hex); CTRL=0.
  - Required: digits 5..0 show "012345"; digit0 shows the glyph for 5 (7'h6D logical, ~ when active-low).
- Scroll wrap:
  - Stimulus: LEN=3, RATE=4, CTRL=1.
  - Required: `pos` steps 0,1,2,3,0 at 4-clock intervals; STATUS reads match.
- Blink:
  - Stimulus: RATE=2, CTRL=2.
  - Required: outputs alternate blank/visible every 2 clocks; clearing CTRL leaves the display visible one clock later.
- Restart vs. step:
  - Stimulus: write CTRL=5 on the exact cycle a `step` would fire.
  - Required: `pos`=0 and prescaler=0 after the edge; the next step comes RATE clocks later.
- Reset mid-scroll:
  - Stimulus: assert `reset_n` low asynchronously while `pos`=7.
  - Required: `pos`, CTRL, RATE, LEN and MSG all return to their reset values immediately, and `hex_out` is all-blank.
- Raw and RATE=0:
  - Stimulus: MSG[0]=8'hFF, RATE=0, CTRL=1.
  - Required: all segments of the leftmost digit are lit, and `pos` increments every clock.
